// File: rtl/gnr_pkg.sv
// Shared state encoding, strobe bundle and default sizes for the GNR
// network cycle controller.
package gnr_pkg;

    localparam int GNR_NUM_NODES = 8;
    localparam int GNR_CNT_W     = 16;
    localparam int GNR_MAX_STEPS = 1000;

    typedef enum logic [3:0] {
        IDLE,
        INIT,
        P1_A,
        P1_B,
        P1_CMP,
        P2_STEP,
        P2_CMP,
        P3_RST,
        P3_ADV,
        P3_CMP,
        P3_A,
        P3_B,
        DONE
    } gnr_state_e;

    typedef struct packed {
        logic reset_nos;
        logic start_s0;
        logic start_s1;
    } gnr_strobe_t;

    // Broadcast pattern held for the cycle(s) the FSM occupies a state.
    function automatic gnr_strobe_t strobe_for(input gnr_state_e st);
        gnr_strobe_t s;
        s = '0;
        case (st)
            INIT, P3_RST:     s.reset_nos = 1'b1;
            P1_A, P1_B, P3_A: begin
                s.start_s0 = 1'b1;
                s.start_s1 = 1'b1;
            end
            P2_STEP, P3_ADV:  s.start_s1 = 1'b1;
            P3_B:             s.start_s0 = 1'b1;
            default:          s = '0;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/gnr_cycle_ctrl.sv
// Drives an array of dual-trajectory GNR nodes and runs three-phase Floyd
// cycle detection on their s0/s1 readback, reporting transient and period.
module gnr_cycle_ctrl
    import gnr_pkg::*;
#(
    parameter int NUM_NODES = GNR_NUM_NODES,
    parameter int CNT_W     = GNR_CNT_W,
    parameter int MAX_STEPS = GNR_MAX_STEPS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [NUM_NODES-1:0] init_in,
    input  logic [NUM_NODES-1:0] sos_s0,
    input  logic [NUM_NODES-1:0] sos_s1,
    output logic                 reset_nos,
    output logic                 start_s0,
    output logic                 start_s1,
    output logic [NUM_NODES-1:0] init_state,
    output logic                 busy,
    output logic                 done,
    output logic                 found,
    output logic [CNT_W-1:0]     mu,
    output logic [CNT_W-1:0]     lambda
);

    localparam logic [CNT_W-1:0] STEP_LIMIT = CNT_W'(MAX_STEPS);

    gnr_state_e           state, state_n;
    gnr_strobe_t          strb, strb_n;
    logic [CNT_W-1:0]     step, step_n;
    logic [CNT_W-1:0]     cnt, cnt_n;
    logic [CNT_W-1:0]     mu_n, lambda_n;
    logic [NUM_NODES-1:0] init_n;
    logic                 busy_n, done_n, found_n;
    logic                 match;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign match     = (sos_s0 == sos_s1);
    assign reset_nos = strb.reset_nos;
    assign start_s0  = strb.start_s0;
    assign start_s1  = strb.start_s1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            strb       <= '0;
            step       <= '0;
            cnt        <= '0;
            mu         <= '0;
            lambda     <= '0;
            init_state <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            found      <= 1'b0;
        end else begin
            state      <= state_n;
            strb       <= strb_n;
            step       <= step_n;
            cnt        <= cnt_n;
            mu         <= mu_n;
            lambda     <= lambda_n;
            init_state <= init_n;
            busy       <= busy_n;
            done       <= done_n;
            found      <= found_n;
        end
    end

    always_comb begin
        state_n  = state;
        step_n   = step;
        cnt_n    = cnt;
        mu_n     = mu;
        lambda_n = lambda;
        init_n   = init_state;
        busy_n   = busy;
        done_n   = done;
        found_n  = found;

        unique case (state)
            IDLE, DONE: begin
                if (start) begin
                    init_n   = init_in;
                    step_n   = '0;
                    mu_n     = '0;
                    lambda_n = '0;
                    done_n   = 1'b0;
                    found_n  = 1'b0;
                    busy_n   = 1'b1;
                    state_n  = INIT;
                end
            end
            INIT:    state_n = P1_A;
            P1_A:    state_n = P1_B;
            P1_B: begin
                step_n  = sat_inc(step);
                state_n = P1_CMP;
            end
            P1_CMP: begin
                if (match) begin
                    lambda_n = '0;
                    state_n  = P2_STEP;
                end else if (step == STEP_LIMIT) begin
                    found_n = 1'b0;
                    done_n  = 1'b1;
                    busy_n  = 1'b0;
                    state_n = DONE;
                end else begin
                    state_n = P1_A;
                end
            end
            // s0 parks on the meet point, which lies on the cycle, so this
            // loop always terminates.
            P2_STEP: begin
                lambda_n = sat_inc(lambda);
                state_n  = P2_CMP;
            end
            P2_CMP:  state_n = match ? P3_RST : P2_STEP;
            P3_RST: begin
                cnt_n   = '0;
                state_n = P3_ADV;
            end
            // One s1 strobe per cycle here; leave once lambda have gone out.
            P3_ADV: begin
                cnt_n = sat_inc(cnt);
                if (cnt_n == lambda)
                    state_n = P3_CMP;
            end
            P3_CMP: begin
                if (match) begin
                    found_n = 1'b1;
                    done_n  = 1'b1;
                    busy_n  = 1'b0;
                    state_n = DONE;
                end else begin
                    state_n = P3_A;
                end
            end
            P3_A:    state_n = P3_B;
            P3_B: begin
                mu_n    = sat_inc(mu);
                state_n = P3_CMP;
            end
            default: state_n = IDLE;
        endcase

        strb_n = strobe_for(state_n);
    end

endmodule

// File: tb/tb_gnr_cycle_ctrl.sv
// Closed-loop bench: behavioural GNR node arrays around two controllers
// (normal step limit and a tiny one for the abandon path).
module tb_gnr_cycle_ctrl;

    localparam int N  = 3;
    localparam int CW = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic [N-1:0] init_in = '0;

    logic a_rst_nos, a_st0, a_st1, a_busy, a_done, a_found;
    logic [N-1:0] a_init, a_sos0, a_sos1;
    logic [CW-1:0] a_mu, a_lambda;
    logic b_rst_nos, b_st0, b_st1, b_busy, b_done, b_found;
    logic [N-1:0] b_init, b_sos0, b_sos1;
    logic [CW-1:0] b_mu, b_lambda;

    int fn_sel = 0;
    int checks = 0;
    int errors = 0;
    int rst_tot = 0;
    int s1_only_tot = 0;
    int s1_snap[128];
    int base_rst = 0;

    initial forever #5 clk = ~clk;

    gnr_cycle_ctrl #(.NUM_NODES(N), .CNT_W(CW), .MAX_STEPS(1000)) dut_a (
        .clk(clk), .rst(rst), .start(start), .init_in(init_in),
        .sos_s0(a_sos0), .sos_s1(a_sos1),
        .reset_nos(a_rst_nos), .start_s0(a_st0), .start_s1(a_st1),
        .init_state(a_init), .busy(a_busy), .done(a_done), .found(a_found),
        .mu(a_mu), .lambda(a_lambda)
    );

    gnr_cycle_ctrl #(.NUM_NODES(N), .CNT_W(CW), .MAX_STEPS(2)) dut_b (
        .clk(clk), .rst(rst), .start(start), .init_in(init_in),
        .sos_s0(b_sos0), .sos_s1(b_sos1),
        .reset_nos(b_rst_nos), .start_s0(b_st0), .start_s1(b_st1),
        .init_state(b_init), .busy(b_busy), .done(b_done), .found(b_found),
        .mu(b_mu), .lambda(b_lambda)
    );

    // 0 ring shift, 1 identity, 2 0->1->2->3->2, 3 mod-8 counter
    function automatic logic [N-1:0] next_fn(input int sel, input logic [N-1:0] s);
        if (sel == 0) return {s[1:0], s[2]};
        if (sel == 1) return s;
        if (sel == 2) return (s == 3'd0) ? 3'd1 : (s == 3'd1) ? 3'd2 :
                             (s == 3'd2) ? 3'd3 : (s == 3'd3) ? 3'd2 : 3'd0;
        return s + 3'd1;
    endfunction

    // Node arrays: s1 steps on every strobe, s0 on every second one.
    logic [N-1:0] a_pass = '1, b_pass = '1;
    logic [N-1:0] a_nx0, a_nx1, b_nx0, b_nx1;
    logic [N-1:0] a_s0 = '0, a_s1 = '0, b_s0 = '0, b_s1 = '0;
    assign a_nx0 = next_fn(fn_sel, a_s0);
    assign a_nx1 = next_fn(fn_sel, a_s1);
    assign b_nx0 = next_fn(fn_sel, b_s0);
    assign b_nx1 = next_fn(fn_sel, b_s1);
    assign a_sos0 = a_s0;
    assign a_sos1 = a_s1;
    assign b_sos0 = b_s0;
    assign b_sos1 = b_s1;

    always @(posedge clk) begin
        if (a_rst_nos) begin
            a_s0 <= a_init; a_s1 <= a_init; a_pass <= '1;
        end else begin
            if (a_st1) a_s1 <= a_nx1;
            if (a_st0) for (int i = 0; i < N; i++) begin
                if (a_pass[i]) a_s0[i] <= a_nx0[i];
                a_pass[i] <= ~a_pass[i];
            end
        end
        if (b_rst_nos) begin
            b_s0 <= b_init; b_s1 <= b_init; b_pass <= '1;
        end else begin
            if (b_st1) b_s1 <= b_nx1;
            if (b_st0) for (int j = 0; j < N; j++) begin
                if (b_pass[j]) b_s0[j] <= b_nx0[j];
                b_pass[j] <= ~b_pass[j];
            end
        end
    end

    always @(negedge clk) begin
        if (a_rst_nos) begin
            rst_tot <= rst_tot + 1;
            s1_snap[(rst_tot + 1) % 128] <= s1_only_tot;
        end
        if (a_st1 && !a_st0) s1_only_tot <= s1_only_tot + 1;
    end

    typedef struct {
        int           fn;
        logic [N-1:0] init;
        int           use_b;
        int           found;
        int           mu;
        int           lambda;
        int           rst_n;
        int           p2;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic launch(input logic [N-1:0] iv);
        init_in  = iv;
        start    = 1'b1;
        base_rst = rst_tot;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_both_done(input string name);
        int n = 0;
        while (!(a_done && b_done) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check({name, "_completes"}, 64'(a_done && b_done), 64'd1);
    endtask

    task automatic wait_strobe(input logic want_s0, input string name);
        int n = 0;
        while (!(a_st1 && (a_st0 == want_s0)) && n < 500) begin
            @(negedge clk);
            n++;
        end
        check({name, "_reached"}, 64'(a_st1 && (a_st0 == want_s0)), 64'd1);
    endtask

    task automatic check_a(input string name, input int f, input int m, input int l);
        check({name, "_found"},  64'(a_found),  64'(f));
        check({name, "_mu"},     64'(a_mu),     64'(m));
        check({name, "_lambda"}, 64'(a_lambda), 64'(l));
        check({name, "_busy"},   64'(a_busy),   64'd0);
        check({name, "_rst_nos"}, 64'(rst_tot - base_rst), 64'd2);
    endtask

    initial begin
        vecs[0] = '{fn: 0, init: 3'b001, use_b: 0, found: 1, mu: 0, lambda: 3, rst_n: 2, p2: 3};
        vecs[1] = '{fn: 1, init: 3'b101, use_b: 0, found: 1, mu: 0, lambda: 1, rst_n: 2, p2: 1};
        vecs[2] = '{fn: 2, init: 3'b000, use_b: 0, found: 1, mu: 2, lambda: 2, rst_n: 2, p2: 2};
        vecs[3] = '{fn: 2, init: 3'b001, use_b: 0, found: 1, mu: 1, lambda: 2, rst_n: 2, p2: 2};
        vecs[4] = '{fn: 3, init: 3'b000, use_b: 0, found: 1, mu: 0, lambda: 8, rst_n: 2, p2: 8};
        vecs[5] = '{fn: 3, init: 3'b000, use_b: 1, found: 0, mu: 0, lambda: 0, rst_n: 0, p2: 0};

        repeat (3) @(negedge clk);
        check("reset_outputs_a", 64'({a_rst_nos, a_st0, a_st1, a_init, a_busy, a_done,
                                      a_found, a_mu, a_lambda}), 64'd0);
        check("reset_outputs_b", 64'({b_rst_nos, b_st0, b_st1, b_init, b_busy, b_done,
                                      b_found, b_mu, b_lambda}), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 6; v++) begin
            fn_sel = vecs[v].fn;
            launch(vecs[v].init);
            check($sformatf("v%0d_busy", v), 64'(a_busy), 64'd1);
            wait_both_done($sformatf("v%0d", v));
            if (vecs[v].use_b != 0) begin
                check($sformatf("v%0d_found", v),  64'(b_found),  64'(vecs[v].found));
                check($sformatf("v%0d_mu", v),     64'(b_mu),     64'(vecs[v].mu));
                check($sformatf("v%0d_lambda", v), 64'(b_lambda), 64'(vecs[v].lambda));
                check($sformatf("v%0d_busy_end", v), 64'(b_busy), 64'd0);
            end else begin
                check($sformatf("v%0d_found", v),  64'(a_found),  64'(vecs[v].found));
                check($sformatf("v%0d_mu", v),     64'(a_mu),     64'(vecs[v].mu));
                check($sformatf("v%0d_lambda", v), 64'(a_lambda), 64'(vecs[v].lambda));
                check($sformatf("v%0d_busy_end", v), 64'(a_busy), 64'd0);
                check($sformatf("v%0d_rst_nos", v), 64'(rst_tot - base_rst),
                      64'(vecs[v].rst_n));
                check($sformatf("v%0d_p2_strobes", v),
                      64'(s1_snap[(base_rst + 2) % 128] - s1_snap[(base_rst + 1) % 128]),
                      64'(vecs[v].p2));
            end
        end

        // Results hold in DONE with no start.
        repeat (5) @(negedge clk);
        check("hold_done",   64'(a_done),   64'd1);
        check("hold_lambda", 64'(a_lambda), 64'd8);

        // start pulses mid-run must not disturb the ring result.
        fn_sel = 0;
        launch(3'b001);
        wait_strobe(1'b1, "p1");
        init_in = 3'b111; start = 1'b1;
        @(negedge clk); start = 1'b0;
        wait_strobe(1'b0, "p2");
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        wait_both_done("ignore");
        check_a("ignore", 1, 0, 3);
        check("ignore_init_state", 64'(a_init), 64'(3'b001));

        // start in DONE relaunches; done falls on the next cycle.
        fn_sel = 1;
        init_in = 3'b101; start = 1'b1; base_rst = rst_tot;
        @(negedge clk);
        start = 1'b0;
        check("relaunch_done_low", 64'(a_done), 64'd0);
        check("relaunch_busy",     64'(a_busy), 64'd1);
        check("relaunch_init",     64'(a_init), 64'(3'b101));
        wait_both_done("relaunch");
        check_a("relaunch", 1, 0, 1);

        // Async reset during P2_STEP, then a clean run.
        fn_sel = 0;
        launch(3'b001);
        wait_strobe(1'b0, "p2_rst");
        rst = 1'b1;
        #1;
        check("midrun_rst_a", 64'({a_rst_nos, a_st0, a_st1, a_init, a_busy, a_done,
                                   a_found, a_mu, a_lambda}), 64'd0);
        check("midrun_rst_b", 64'({b_rst_nos, b_st0, b_st1, b_init, b_busy, b_done,
                                   b_found, b_mu, b_lambda}), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("post_rst_idle", 64'({a_rst_nos, a_st0, a_st1, a_busy, a_done}), 64'd0);
        launch(3'b010);
        wait_both_done("post_rst");
        check_a("post_rst", 1, 0, 3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gnr_cycle_ctrl.md
Name: gnr_cycle_ctrl

Overview:
Network-level controller that drives an array of NUM_NODES dual-trajectory GNR nodes and reads their state back. It broadcasts reset_nos, start_s0 and start_s1 to the nodes. It compares the slow (s0) and fast (s1) state vectors and runs Floyd cycle detection in three phases. It reports transient length (mu) and attractor period (lambda) to the host/FDAM wrapper.

Parameters:
NUM_NODES, 8, number of GNR nodes (width of state vectors)
CNT_W, 16, width of the mu, lambda and step counters
MAX_STEPS, 1000, phase-1 step limit before the run is abandoned

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
start  in  1  run request; sampled in IDLE or DONE
init_in  in  NUM_NODES  initial network state; captured on accepted start
sos_s0  in  NUM_NODES  concatenated node s0 outputs (slow trajectory)
sos_s1  in  NUM_NODES  concatenated node s1 outputs (fast trajectory)
reset_nos  out  1  broadcast: load init_state into s0/s1, set node pass=1
start_s0  out  1  broadcast s0 step strobe (a node updates s0 on every second strobe after reset_nos)
start_s1  out  1  broadcast s1 step strobe (a node updates s1 on every strobe)
init_state  out  NUM_NODES  registered copy of init_in, bit i goes to node i
busy  out  1  run in progress
done  out  1  result valid; held until the next accepted start
found  out  1  attractor found (0 means timeout)
mu  out  CNT_W  transient length
lambda  out  CNT_W  attractor period

Behaviour:
- Reset (async): FSM=IDLE. All outputs 0, all counters 0.
- Node outputs are registered. A strobe issued in cycle t is visible on sos_* in cycle t+1. The controller compares sos_s0 == sos_s1 only in *_CMP states, one cycle after the last strobe.
- All strobes are registered outputs, high for exactly one cycle per state visit.
- IDLE/DONE + start=1: capture init_in into init_state. Clear done, found, mu, lambda and step. Set busy=1. Go to INIT.
- start while busy: ignored.
- INIT: reset_nos=1 (1 cycle) -> P1_A.
- Phase 1, meet:
  - P1_A: start_s0=1, start_s1=1 (s0 and s1 advance).
  - P1_B: start_s0=1, start_s1=1 (s0 skips, s1 advances). step++.
  - P1_CMP: if equal -> P2_STEP with lambda=0. Else if step==MAX_STEPS -> DONE with found=0. Else -> P1_A.
- Phase 2, period; s0 held:
  - P2_STEP: start_s1=1, lambda++.
  - P2_CMP: equal -> P3_RST. Else -> P2_STEP. No timeout is needed because the meet point lies on the cycle.
- Phase 3, transient:
  - P3_RST: reset_nos=1, cnt=0.
  - P3_ADV: start_s1=1, cnt++. Stay until cnt==lambda, so exactly lambda strobes are issued. Then -> P3_CMP.
  - P3_CMP: equal -> DONE with found=1. Else -> P3_A.
  - P3_A: start_s0=1, start_s1=1 (both advance; node pass was 1).
  - P3_B: start_s0=1 only (s0 skips, pass returns to 1). mu++ -> P3_CMP.
- DONE: busy=0, done=1. mu, lambda and found are stable.
- mu=0 case: P3_CMP hits on its first visit.
- lambda=1 (fixed point): P2 runs exactly one step.
- Counters saturate at 2^CNT_W-1. No wrap-around.
- rst asserted mid-run: immediate return to IDLE with outputs 0. Node contents are don't-care; the next run issues reset_nos.

Decomposition:
- Package gnr_pkg holds:
  - the state enum (IDLE, INIT, P1_A, P1_B, P1_CMP, P2_STEP, P2_CMP, P3_RST, P3_ADV, P3_CMP, P3_A, P3_B, DONE);
  - the default CNT_W and NUM_NODES constants.
- Single module; no sub-module is warranted.
- The bench instantiates NUM_NODES node models with a user next-state function to close the loop.

Test Plan:
- Ring shift, NUM_NODES=3, init 001 (001->010->100->001) -> done, found=1, mu=0, lambda=3.
- Identity network, init 101 -> found=1, mu=0, lambda=1. Phase 2 issues exactly one start_s1 strobe.
- Sequence 000->001->010->011->010, init 000 -> found=1, mu=2, lambda=2. reset_nos is seen exactly twice per run.
- 3-bit counter (period 8) with MAX_STEPS=2 -> done after 2 P1 steps, found=0, mu=0, lambda=0.
- start pulsed during P1 and P2 -> ignored, and results match an undisturbed run. start in DONE -> new run, done drops next cycle.
- rst asserted during P2_STEP -> all outputs 0 asynchronously, FSM IDLE. A following start completes correctly.
